// File: rtl/cmp_arb_pkg.sv
// Shared types, funct3 codes and decode helpers for the shared comparator arbiter.
package cmp_arb_pkg;

   localparam int CMP_DATA_W = 32;

   localparam logic [2:0] F3_EQ   = 3'b000;
   localparam logic [2:0] F3_NE   = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_LT   = 3'b100;
   localparam logic [2:0] F3_GE   = 3'b101;
   localparam logic [2:0] F3_LTU  = 3'b110;
   localparam logic [2:0] F3_GEU  = 3'b111;

   // Tags travel beside these structs so TAG_W stays a per-instance parameter.
   typedef struct packed {
      logic [CMP_DATA_W-1:0] a;
      logic [CMP_DATA_W-1:0] b;
      logic [2:0]            op;
   } cmp_req_t;

   typedef struct packed {
      logic port;
      logic result;
   } cmp_rsp_t;

   function automatic logic decode_unsigned(input logic [2:0] op);
      return (op == F3_SLTU) || (op == F3_LTU) || (op == F3_GEU);
   endfunction

   function automatic logic decode_use_eq(input logic [2:0] op);
      return (op == F3_EQ) || (op == F3_NE);
   endfunction

   function automatic logic decode_invert(input logic [2:0] op);
      return (op == F3_NE) || (op == F3_GE) || (op == F3_GEU);
   endfunction

endpackage

// File: rtl/cmp_datapath.sv
// 32-bit comparator datapath: equality plus signed/unsigned less-than.
module cmp_datapath
   import cmp_arb_pkg::*;
(
   input  logic [CMP_DATA_W-1:0] a_i,
   input  logic [CMP_DATA_W-1:0] b_i,
   input  logic                  unsigned_i,
   output logic                  eq_o,
   output logic                  lt_o
);

   assign eq_o = (a_i == b_i);
   assign lt_o = unsigned_i ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/cmp_rr_arb2.sv
// Two-way one-hot grant logic with round-robin pointer.
// Defining CMP_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) and drops the pointer.
module cmp_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

`ifdef CMP_ARB_FIXED_PRIO_EN

   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i[0]) begin
            gnt_o = 2'b01;
         end else if (req_i[1]) begin
            gnt_o = 2'b10;
         end
      end
   end

`else

   logic rr_ptr_q;
   logic rr_ptr_d;

   // rr_ptr names the preferred port when both request.
   always_comb begin
      gnt_o    = 2'b00;
      rr_ptr_d = rr_ptr_q;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o[rr_ptr_q] = 1'b1;
         end else begin
            gnt_o = req_i;
         end
      end
      if (gnt_o != 2'b00) begin
         rr_ptr_d = ~gnt_o[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

`endif

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one 32-bit comparator between branch (port 0) and ALU SLT (port 1); registered
// 1-bit result returned over valid/ready. Arbitration mode set by CMP_ARB_FIXED_PRIO_EN.
module cmp_share_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic [1:0]                  req_valid_i,
   output logic [1:0]                  req_ready_o,
   input  logic [1:0][DATA_W-1:0]      req_a_i,
   input  logic [1:0][DATA_W-1:0]      req_b_i,
   input  logic [1:0][2:0]             req_op_i,
   input  logic [1:0][TAG_W-1:0]       req_tag_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic                        rsp_port_o,
   output logic                        rsp_result_o,
   output logic [TAG_W-1:0]            rsp_tag_o
);

   cmp_req_t          req_s [2];
   logic [1:0]        gnt;
   logic              gnt_any;
   logic              gnt_port;
   logic              can_issue;
   cmp_req_t          sel_req;
   logic [TAG_W-1:0]  sel_tag;
   logic              unsigned_op;
   logic              cmp_eq;
   logic              cmp_lt;
   logic              cmp_result;

   logic              rsp_valid_q, rsp_valid_d;
   cmp_rsp_t          rsp_q, rsp_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_s[gi] = '{a: req_a_i[gi], b: req_b_i[gi], op: req_op_i[gi]};
      end
   endgenerate

   // Held output or flush blocks issue; reset also forces no grant.
   assign can_issue = rst_n && !flush_i && (!rsp_valid_q || rsp_ready_i);

   cmp_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (can_issue),
      .req_i (req_valid_i),
      .gnt_o (gnt)
   );

   assign req_ready_o = gnt;
   assign gnt_any     = |gnt;
   assign gnt_port    = gnt[1];
   assign sel_req     = req_s[gnt_port];
   assign sel_tag     = req_tag_i[gnt_port];
   assign unsigned_op = decode_unsigned(sel_req.op);

   cmp_datapath u_cmp (
      .a_i        (sel_req.a),
      .b_i        (sel_req.b),
      .unsigned_i (unsigned_op),
      .eq_o       (cmp_eq),
      .lt_o       (cmp_lt)
   );

   assign cmp_result = (decode_use_eq(sel_req.op) ? cmp_eq : cmp_lt) ^ decode_invert(sel_req.op);

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      rsp_tag_d   = rsp_tag_q;
      if (flush_i) begin
         rsp_valid_d = 1'b0;
      end else if (gnt_any) begin
         rsp_valid_d   = 1'b1;
         rsp_d.port    = gnt_port;
         rsp_d.result  = cmp_result;
         rsp_tag_d     = sel_tag;
      end else if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         rsp_tag_q   <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_port_o   = rsp_q.port;
   assign rsp_result_o = rsp_q.result;
   assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: cycle model with result scoreboard,
// table of port-0 compare vectors, and directed stall/flush/reset sequences.
module tb_cmp_share_arbiter;

   localparam int TAG_W = 5;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   flush_i;
   logic [1:0]             req_valid_i;
   logic [1:0]             req_ready_o;
   logic [1:0][31:0]       req_a_i;
   logic [1:0][31:0]       req_b_i;
   logic [1:0][2:0]        req_op_i;
   logic [1:0][TAG_W-1:0]  req_tag_i;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i;
   logic                   rsp_port_o;
   logic                   rsp_result_o;
   logic [TAG_W-1:0]       rsp_tag_o;

   always #5 clk = ~clk;

   cmp_share_arbiter #(.DATA_W(32), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_op_i     (req_op_i),
      .req_tag_i    (req_tag_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_port_o   (rsp_port_o),
      .rsp_result_o (rsp_result_o),
      .rsp_tag_o    (rsp_tag_o)
   );

   typedef struct {
      logic             port;
      logic             result;
      logic [TAG_W-1:0] tag;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic m_valid = 1'b0;
   logic m_rr = 1'b0;
   logic exp_g_any;
   logic exp_g;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:         return a == b;
         3'b001:         return a != b;
         3'b010, 3'b100: return $signed(a) < $signed(b);
         3'b011, 3'b110: return a < b;
         3'b101:         return $signed(a) >= $signed(b);
         default:        return a >= b;
      endcase
   endfunction

   // One clock: compare at negedge against the model, then advance the model.
   task automatic cycle();
      logic       can;
      logic [1:0] er;
      logic       g;
      exp_t       e;
      @(negedge clk);
      can = rst_n && !flush_i && (!m_valid || rsp_ready_i);
      er  = 2'b00;
      g   = 1'b0;
      if (can && req_valid_i != 2'b00) begin
         if (req_valid_i == 2'b11) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = m_rr;
`endif
         end else begin
            g = req_valid_i[1];
         end
         er[g] = 1'b1;
      end
      check("req_ready", {62'd0, req_ready_o}, {62'd0, er});
      check("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, m_valid});
      if (m_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         check("rsp_port", {63'd0, rsp_port_o}, {63'd0, e.port});
         check("rsp_result", {63'd0, rsp_result_o}, {63'd0, e.result});
         check("rsp_tag", {59'd0, rsp_tag_o}, {59'd0, e.tag});
      end
      exp_g_any = |er;
      exp_g     = g;
      $display("cyc t=%0t rst_n=%0b flush=%0b valid=%b ready_in=%0b exp_gnt=%b rsp_v=%0b port=%0b res=%0b tag=%0d",
               $time, rst_n, flush_i, req_valid_i, rsp_ready_i, er, rsp_valid_o, rsp_port_o, rsp_result_o, rsp_tag_o);
      if (!rst_n) begin
         m_valid = 1'b0;
         m_rr    = 1'b0;
         exp_q.delete();
      end else if (flush_i) begin
         m_valid = 1'b0;
         exp_q.delete();
      end else begin
         if (m_valid && rsp_ready_i) begin
            void'(exp_q.pop_front());
            m_valid = 1'b0;
         end
         if (|er) begin
            e.port   = g;
            e.result = golden(req_op_i[g], req_a_i[g], req_b_i[g]);
            e.tag    = req_tag_i[g];
            exp_q.push_back(e);
            m_valid  = 1'b1;
            m_rr     = ~g;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick_operand(input logic [31:0] other);
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return other;
         3:       return $urandom_range(0, 3);
         default: return $urandom;
      endcase
   endfunction

   task automatic new_request(input int p);
      req_op_i[p]  = 3'($urandom_range(0, 7));
      req_a_i[p]   = $urandom;
      req_b_i[p]   = pick_operand(req_a_i[p]);
      req_tag_i[p] = TAG_W'($urandom);
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{op: 3'b100, a: 32'hFFFF_FFFF, b: 32'h1,         exp: 1'b1};
      tbl[1] = '{op: 3'b110, a: 32'hFFFF_FFFF, b: 32'h1,         exp: 1'b0};
      tbl[2] = '{op: 3'b111, a: 32'hFFFF_FFFF, b: 32'h1,         exp: 1'b1};
      tbl[3] = '{op: 3'b000, a: 32'h1234,      b: 32'h1234,      exp: 1'b1};
      tbl[4] = '{op: 3'b001, a: 32'h1234,      b: 32'h1234,      exp: 1'b0};
      tbl[5] = '{op: 3'b011, a: 32'h1,         b: 32'hFFFF_FFFF, exp: 1'b1};
      tbl[6] = '{op: 3'b101, a: 32'h8000_0000, b: 32'h0,         exp: 1'b0};
      tbl[7] = '{op: 3'b010, a: 32'h5,         b: 32'h5,         exp: 1'b0};

      // Reset with both requesters asserting.
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      rsp_ready_i = 1'b1;
      req_valid_i = 2'b11;
      new_request(0);
      new_request(1);
      cycle();
      cycle();
      rst_n       = 1'b1;
      req_valid_i = 2'b00;
      cycle();

      // Port 0 compare vectors, back-to-back with ready high.
      for (int i = 0; i < 8; i++) begin
         req_valid_i  = 2'b01;
         req_op_i[0]  = tbl[i].op;
         req_a_i[0]   = tbl[i].a;
         req_b_i[0]   = tbl[i].b;
         req_tag_i[0] = TAG_W'(i);
         cycle();
         req_valid_i  = 2'b00;
         check("tbl_valid", {63'd0, rsp_valid_o}, 64'd1);
         check("tbl_result", {63'd0, rsp_result_o}, {63'd0, tbl[i].exp});
         check("tbl_tag", {59'd0, rsp_tag_o}, 64'(i));
      end
      cycle();

      // Contention with ready high: alternating grants, one result per cycle.
      req_valid_i = 2'b11;
      for (int i = 0; i < 6; i++) begin
         new_request(0);
         new_request(1);
         cycle();
      end

      // Output stall for 3 cycles, then drain and issue in the same cycle.
      rsp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      rsp_ready_i = 1'b1;
      cycle();
      req_valid_i = 2'b00;
      cycle();

      // Flush with a pending result and port 1 SLT waiting.
      req_valid_i  = 2'b10;
      req_op_i[1]  = 3'b010;
      req_a_i[1]   = 32'hFFFF_FFF0;
      req_b_i[1]   = 32'h10;
      req_tag_i[1] = 5'd17;
      cycle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      req_valid_i = 2'b11;
      cycle();
      req_valid_i = 2'b00;
      cycle();

      // Reset while a result is held.
      req_valid_i = 2'b01;
      rsp_ready_i = 1'b0;
      new_request(0);
      cycle();
      req_valid_i = 2'b00;
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      rsp_ready_i = 1'b1;
      cycle();

      // Random traffic; requesters hold their request until granted.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req_valid_i[p] && $urandom_range(0, 9) < 6) begin
               new_request(p);
               req_valid_i[p] = 1'b1;
            end
         end
         flush_i     = ($urandom_range(0, 19) == 0);
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
         if (flush_i) begin
            req_valid_i = 2'b00;
         end else if (exp_g_any) begin
            req_valid_i[exp_g] = 1'b0;
         end
      end

      flush_i     = 1'b0;
      req_valid_i = 2'b00;
      rsp_ready_i = 1'b1;
      cycle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
